// File: rtl/ram_line_master_pkg.sv
// Shared types and helpers for the cache-side SRAM bus initiator.
// Holds the controller state encoding and the line-offset width calculation.
package ram_line_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      TURN
   } state_t;

   localparam int BYTES_PER_WORD = 4;

   // Number of low byte-address bits that select a byte inside one cache line.
   function automatic int line_off_bits(input int line_words);
      return $clog2(line_words * BYTES_PER_WORD);
   endfunction

endpackage

// File: rtl/ram_line_master.sv
// SRAM-bus initiator between the cache and the on-chip ram model: whole-line read
// bursts, single word/byte write-through stores, and a turnaround cycle after every access.
module ram_line_master
   import ram_line_master_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_bw,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_data,
   output logic [((LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1)-1:0] rsp_beat,
   output logic                  rsp_last,
   output logic [31:0]           addr,
   inout  wire  [31:0]           data,
   output logic                  ce_n,
   output logic                  we_n,
   output logic                  oe_n,
   output logic                  bw
);

   localparam int BEAT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int OFF_W    = line_off_bits(LINE_WORDS);
   localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [BEAT_W-1:0]   beat_inc;
   logic [31:0]         base_q, base_d;
   logic [31:0]         addr_q, addr_d;
   logic                bw_q, bw_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                drive_q, drive_d;
   logic                ce_n_q, ce_n_d;
   logic                we_n_q, we_n_d;
   logic                oe_n_q, oe_n_d;
   logic                ready_q, ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_last_q, rsp_last_d;
   logic [31:0]         rsp_data_q, rsp_data_d;
   logic [BEAT_W-1:0]   rsp_beat_q, rsp_beat_d;
   logic                last_beat;

   assign beat_inc  = beat_q + BEAT_W'(1);
   assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

   // Every bus-facing and response output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         beat_q      <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         bw_q        <= 1'b1;
         wdata_q     <= '0;
         drive_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_beat_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         beat_q      <= beat_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         bw_q        <= bw_d;
         wdata_q     <= wdata_d;
         drive_q     <= drive_d;
         ce_n_q      <= ce_n_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
         rsp_beat_q  <= rsp_beat_d;
      end
   end

   // Next-state logic computes the bus values for the following cycle, so strobes change on clean edges.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      beat_d      = beat_q;
      base_d      = base_q;
      addr_d      = addr_q;
      bw_d        = 1'b1;
      wdata_d     = wdata_q;
      drive_d     = 1'b0;
      ce_n_d      = 1'b1;
      we_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_beat_d  = rsp_beat_q;

      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               wait_d = '0;
               ce_n_d = 1'b0;
               if (req_we) begin
                  state_d = WR;
                  addr_d  = req_addr;
                  bw_d    = req_bw;
                  wdata_d = req_wdata;
                  we_n_d  = 1'b0;
                  drive_d = 1'b1;
               end else begin
                  state_d = RD;
                  base_d  = req_addr & LINE_MASK;
                  addr_d  = req_addr & LINE_MASK;
                  beat_d  = '0;
                  oe_n_d  = 1'b0;
               end
            end else begin
               ready_d = 1'b1;
            end
         end

         RD: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            if (wait_q == WAIT_W'(READ_WAIT - 1)) begin
               wait_d      = '0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = data;
               rsp_beat_d  = beat_q;
               rsp_last_d  = last_beat;
               beat_d      = beat_inc;
               if (last_beat) begin
                  state_d = TURN;
                  ce_n_d  = 1'b1;
                  oe_n_d  = 1'b1;
               end else begin
                  // The base is line aligned, so the beat bits never carry out of the line.
                  addr_d = base_q | (32'(beat_inc) << 2);
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         WR: begin
            ce_n_d  = 1'b0;
            we_n_d  = 1'b0;
            drive_d = 1'b1;
            bw_d    = bw_q;
            if (wait_q == WAIT_W'(WRITE_WAIT - 1)) begin
               state_d = TURN;
               wait_d  = '0;
               ce_n_d  = 1'b1;
               we_n_d  = 1'b1;
               drive_d = 1'b0;
               bw_d    = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         TURN: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data      = drive_q ? wdata_q : 32'bz;
   assign addr      = addr_q;
   assign bw        = bw_q;
   assign ce_n      = ce_n_q;
   assign we_n      = we_n_q;
   assign oe_n      = oe_n_q;
   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_beat  = rsp_beat_q;

endmodule

// File: tb/tb_ram_line_master.sv
// Bench for ram_line_master: directed vector table, hand-written corner sequences and
// random traffic checked against a byte-level memory model; a second instance uses READ_WAIT = 3.
module tb_ram_line_master;

   localparam int LW   = 4;
   localparam int RW   = 1;
   localparam int WW   = 1;
   localparam int TMAX = 8192;
   localparam logic [31:0] FLOAT     = 32'hFFFF_FFFF;
   localparam logic [31:0] LINE_MASK = ~32'(LW * 4 - 1);

   typedef logic [LW-1:0][31:0] line_t;
   typedef struct {
      logic        we;
      logic        bw;
      logic [31:0] addr;
      logic [31:0] wdata;
      line_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_bw = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_last, ce_n, we_n, oe_n, bw;
   logic [31:0] rsp_data, addr;
   logic [1:0]  rsp_beat;
   tri1  [31:0] data;

   logic        req_valid3 = 1'b0;
   logic [31:0] req_addr3 = '0;
   logic        req_ready3, rsp_valid3, rsp_last3, ce3_n, we3_n, oe3_n, bw3;
   logic [31:0] rsp_data3, addr3;
   logic [1:0]  rsp_beat3;
   tri1  [31:0] data3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   ram_line_master #(.LINE_WORDS(LW), .READ_WAIT(RW), .WRITE_WAIT(WW)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_bw(req_bw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_beat(rsp_beat), .rsp_last(rsp_last),
      .addr(addr), .data(data), .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n), .bw(bw)
   );

   ram_line_master #(.LINE_WORDS(LW), .READ_WAIT(3), .WRITE_WAIT(WW)) u_dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_we(1'b0), .req_bw(1'b1), .req_addr(req_addr3), .req_wdata(32'h0),
      .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_beat(rsp_beat3), .rsp_last(rsp_last3),
      .addr(addr3), .data(data3), .ce_n(ce3_n), .we_n(we3_n), .oe_n(oe3_n), .bw(bw3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Untouched memory reads back as an address-derived pattern.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[17:2], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   // RAM attached to the main instance: writes land at the clock edge, reads present data 1ns after it.
   logic [31:0] ram_mem [logic [29:0]];
   logic [31:0] ram_out = '0;
   logic [31:0] ram_tmp;

   function automatic logic [31:0] ram_read(input logic [31:0] a);
      if (ram_mem.exists(a[31:2])) return ram_mem[a[31:2]];
      return init_word({a[31:2], 2'b00});
   endfunction

   always @(posedge clk) begin
      if (ce_n === 1'b0 && we_n === 1'b0) begin
         ram_tmp = ram_read(addr);
         if (bw) ram_tmp = data;
         else ram_tmp[{addr[1:0], 3'b000} +: 8] = data[7:0];
         ram_mem[addr[31:2]] = ram_tmp;
      end
      #1 ram_out = ram_read(addr);
   end

   assign data  = (ce_n === 1'b0 && oe_n === 1'b0) ? ram_out : 32'bz;
   assign data3 = (ce3_n === 1'b0 && oe3_n === 1'b0) ? init_word(addr3) : 32'bz;

   // Reference memory, kept per byte and updated at transaction level.
   logic [7:0] ref_b [logic [31:0]];

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] base = {a[31:2], 2'b00};
      logic [31:0] dflt = init_word(base);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = ref_b.exists(base + 32'(i)) ? ref_b[base + 32'(i)] : dflt[8*i +: 8];
      return r;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic wbw, input logic [31:0] d);
      if (wbw) for (int i = 0; i < 4; i++) ref_b[{a[31:2], 2'b00} + 32'(i)] = d[8*i +: 8];
      else ref_b[a] = d[7:0];
   endtask

   // Per-cycle trace, indexed by the number of rising edges seen so far.
   logic [3:0]  t_str   [TMAX];
   logic [31:0] t_addr  [TMAX];
   logic [31:0] t_data  [TMAX];
   logic [31:0] t_rdata [TMAX];
   logic [1:0]  t_beat  [TMAX];
   logic        t_rv    [TMAX];
   logic        t_last  [TMAX];
   logic        t_ready [TMAX];

   always @(negedge clk) begin
      if (cyc < TMAX) begin
         t_str[cyc]   = {ce_n, oe_n, we_n, bw};
         t_addr[cyc]  = addr;
         t_data[cyc]  = data;
         t_rdata[cyc] = rsp_data;
         t_beat[cyc]  = rsp_beat;
         t_rv[cyc]    = rsp_valid;
         t_last[cyc]  = rsp_last;
         t_ready[cyc] = req_ready;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      for (int n = 0; n < 2000 && cyc <= c; n++) @(negedge clk);
   endtask

   // Present one request and hold it until the block takes it; returns the accepting edge number.
   task automatic applyStimulus(input logic we, input logic wbw, input logic [31:0] a,
                                input logic [31:0] wd, output int acc);
      req_we = we; req_bw = wbw; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      acc = -1;
      for (int n = 0; n < 50; n++) begin
         if (req_ready === 1'b1) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (acc < 0) begin
         errors++;
         $display("[TB] FAIL accept_timeout actual=req_ready low required=accepted within 50 cycles");
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic write_txn(input logic [31:0] a, input logic wbw, input logic [31:0] wd, output int acc);
      ref_store(a, wbw, wd);
      applyStimulus(1'b1, wbw, a, wd, acc);
   endtask

   task automatic read_txn(input logic [31:0] a, output int acc, output line_t exp);
      for (int k = 0; k < LW; k++) exp[k] = ref_word((a & LINE_MASK) + 32'(4 * k));
      applyStimulus(1'b0, 1'b1, a, 32'h0, acc);
   endtask

   task automatic check_read(input int acc, input logic [31:0] a, input line_t exp);
      logic [31:0] base = a & LINE_MASK;
      if (acc < 0 || acc + LW + 2 >= TMAX) return;
      wait_until(acc + LW + 2);
      for (int k = 0; k < LW; k++) begin
         checkOutput("rd_strobes", t_str[acc + k], 4'b0011);
         checkOutput("rd_addr", t_addr[acc + k], base + 32'(4 * k));
         checkOutput("rd_valid", t_rv[acc + 1 + k], 1);
         checkOutput("rd_data", t_rdata[acc + 1 + k], exp[k]);
         checkOutput("rd_beat", t_beat[acc + 1 + k], 32'(k));
         checkOutput("rd_last", t_last[acc + 1 + k], (k == LW - 1) ? 1 : 0);
      end
      checkOutput("rd_valid_pre", t_rv[acc], 0);
      checkOutput("rd_valid_post", t_rv[acc + LW + 1], 0);
      checkOutput("rd_turn_strobes", t_str[acc + LW][3:1], 3'b111);
      checkOutput("rd_turn_bus", t_data[acc + LW], FLOAT);
      for (int c = acc; c <= acc + LW; c++) checkOutput("rd_busy_ready", t_ready[c], 0);
      checkOutput("rd_ready_return", t_ready[acc + LW + 1], 1);
   endtask

   task automatic check_write(input int acc, input logic [31:0] a, input logic wbw, input logic [31:0] wd);
      if (acc < 0 || acc + 3 >= TMAX) return;
      wait_until(acc + 2);
      checkOutput("wr_strobes", t_str[acc], {3'b010, wbw});
      checkOutput("wr_addr", t_addr[acc], a);
      checkOutput("wr_data", t_data[acc], wd);
      checkOutput("wr_turn_strobes", t_str[acc + 1][3:1], 3'b111);
      checkOutput("wr_turn_bus", t_data[acc + 1], FLOAT);
      checkOutput("wr_busy_ready", {31'b0, t_ready[acc]} | {31'b0, t_ready[acc + 1]}, 0);
      checkOutput("wr_ready_return", t_ready[acc + 2], 1);
   endtask

   vec_t tbl [9];

   initial begin
      int    acc, acc_w, acc_r, acc3, cnt;
      line_t exp;
      logic [31:0] a, wd;
      logic  we, wbw, exp_v;

      tbl[0] = '{we:1'b1, bw:1'b1, addr:32'h2000_0000, wdata:32'h1122_3344, exp:'0};
      tbl[1] = '{we:1'b1, bw:1'b1, addr:32'h2000_0004, wdata:32'h5566_7788, exp:'0};
      tbl[2] = '{we:1'b1, bw:1'b1, addr:32'h2000_0008, wdata:32'h99AA_BBCC, exp:'0};
      tbl[3] = '{we:1'b1, bw:1'b1, addr:32'h2000_000C, wdata:32'hDDEE_FF00, exp:'0};
      tbl[4] = '{we:1'b1, bw:1'b0, addr:32'h2000_0005, wdata:32'h0000_00A5, exp:'0};
      tbl[5] = '{we:1'b1, bw:1'b0, addr:32'h2000_000F, wdata:32'h0000_003C, exp:'0};
      tbl[6] = '{we:1'b0, bw:1'b1, addr:32'h2000_0008, wdata:32'h0,
                 exp:{32'h3CEE_FF00, 32'h99AA_BBCC, 32'h5566_A588, 32'h1122_3344}};
      tbl[7] = '{we:1'b1, bw:1'b0, addr:32'h2000_0000, wdata:32'hFFFF_FF5A, exp:'0};
      tbl[8] = '{we:1'b0, bw:1'b1, addr:32'h2000_000C, wdata:32'h0,
                 exp:{32'h3CEE_FF00, 32'h99AA_BBCC, 32'h5566_A588, 32'h1122_335A}};

      // Reset held for three edges, then released.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_ready", req_ready, 0);
         checkOutput("rst_strobes", {ce_n, oe_n, we_n, bw}, 4'hF);
         checkOutput("rst_bus", data, FLOAT);
         checkOutput("rst_rsp", {rsp_valid, rsp_last, rsp_beat}, 0);
         checkOutput("rst_rsp_data", rsp_data, 0);
         checkOutput("rst_addr", addr, 0);
      end
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rel_ready", req_ready, 1);
      checkOutput("rel_strobes", {ce_n, oe_n, we_n}, 3'b111);

      $display("[TB] line read from mid-line address");
      read_txn(32'h1001_0008, acc, exp);
      check_read(acc, 32'h1001_0008, exp);

      $display("[TB] byte write then read-back");
      write_txn(32'h1001_0003, 1'b0, 32'h0000_00A5, acc);
      check_write(acc, 32'h1001_0003, 1'b0, 32'h0000_00A5);
      read_txn(32'h1001_0000, acc, exp);
      check_read(acc, 32'h1001_0000, exp);
      if (acc >= 0) checkOutput("byte_lane", t_rdata[acc + 1][31:24], 8'hA5);

      $display("[TB] read queued behind a write");
      write_txn(32'h1001_0004, 1'b1, 32'h0BAD_F00D, acc_w);
      read_txn(32'h1001_0004, acc_r, exp);
      checkOutput("b2b_accept_gap", 32'(acc_r - acc_w), 32'(WW + 2));
      check_write(acc_w, 32'h1001_0004, 1'b1, 32'h0BAD_F00D);
      check_read(acc_r, 32'h1001_0004, exp);
      if (acc_w >= 0 && acc_r > acc_w) begin
         cnt = 0;
         for (int c = acc_w + 1; c < acc_r; c++) if (t_str[c][3]) cnt++;
         checkOutput("b2b_ce_gap", 32'(cnt), 2);
         checkOutput("b2b_new_word", t_rdata[acc_r + 2], 32'h0BAD_F00D);
      end

      $display("[TB] vector table");
      foreach (tbl[i]) begin
         if (tbl[i].we) begin
            write_txn(tbl[i].addr, tbl[i].bw, tbl[i].wdata, acc);
            check_write(acc, tbl[i].addr, tbl[i].bw, tbl[i].wdata);
         end else begin
            applyStimulus(1'b0, 1'b1, tbl[i].addr, 32'h0, acc);
            check_read(acc, tbl[i].addr, tbl[i].exp);
         end
      end

      $display("[TB] reset during a burst");
      read_txn(32'h1001_0000, acc, exp);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_strobes", {ce_n, oe_n, we_n, bw}, 4'hF);
      checkOutput("abort_bus", data, FLOAT);
      checkOutput("abort_rsp", {rsp_valid, rsp_last}, 0);
      checkOutput("abort_ready", req_ready, 0);
      reset = 1'b0;
      wait_until(acc + 10);
      if (acc >= 0) begin
         cnt = 0;
         for (int c = acc + 2; c <= acc + 10; c++) if (t_rv[c]) cnt++;
         checkOutput("abort_no_rsp", 32'(cnt), 0);
         checkOutput("abort_ready_back", t_ready[acc + 3], 1);
      end
      read_txn(32'hFFFF_FFF8, acc, exp);
      check_read(acc, 32'hFFFF_FFF8, exp);

      $display("[TB] random traffic");
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         we  = 1'($urandom_range(0, 1));
         wbw = 1'($urandom_range(0, 1));
         a   = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 : 32'h3000_0000) + 32'($urandom_range(0, 63));
         wd  = $urandom;
         if (wd == FLOAT) wd = 32'h0;
         if (we) begin
            if (wbw) a = {a[31:2], 2'b00};
            write_txn(a, wbw, wd, acc);
            check_write(acc, a, wbw, wd);
         end else begin
            read_txn(a, acc, exp);
            check_read(acc, a, exp);
         end
      end

      $display("[TB] READ_WAIT = 3 line at the top of memory");
      req_addr3  = 32'hFFFF_FFF4;
      req_valid3 = 1'b1;
      acc3 = -1;
      for (int n = 0; n < 50; n++) begin
         if (req_ready3 === 1'b1) begin
            acc3 = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("rw3_accept", (acc3 >= 0) ? 1 : 0, 1);
      @(negedge clk);
      req_valid3 = 1'b0;
      cnt = 0;
      for (int p = 0; p < 14; p++) begin
         if (p > 0) @(negedge clk);
         if (p < 12) begin
            checkOutput("rw3_strobes", {ce3_n, oe3_n, we3_n}, 3'b001);
            checkOutput("rw3_addr", addr3, 32'hFFFF_FFF0 + 32'(4 * (p / 3)));
         end else begin
            checkOutput("rw3_idle_strobes", {ce3_n, oe3_n, we3_n}, 3'b111);
         end
         if (!ce3_n) cnt++;
         exp_v = (p >= 3 && p <= 12 && p % 3 == 0);
         checkOutput("rw3_valid", rsp_valid3, exp_v);
         if (exp_v) begin
            checkOutput("rw3_data", rsp_data3, init_word(32'hFFFF_FFF0 + 32'(4 * (p / 3 - 1))));
            checkOutput("rw3_beat", rsp_beat3, 32'(p / 3 - 1));
            checkOutput("rw3_last", rsp_last3, (p == 12) ? 1 : 0);
         end
         checkOutput("rw3_ready", req_ready3, (p == 13) ? 1 : 0);
      end
      checkOutput("rw3_bus_cycles", 32'(cnt), 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
